// File: rtl/mem_pkg.sv
// Shared constants and FSM state encoding for the memory bus initiator.
// Imported by the initiator RTL and reused by benches driving mem_ifc.
package mem_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_CMD,
    RD_CMD,
    RD_WAIT,
    RESP
  } mem_init_state_e;

endpackage

// File: rtl/mem_sat_cnt.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
// Used for the completed-write and completed-read tallies.
module mem_sat_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != 16'hFFFF)) begin
      q <= q + 16'd1;
    end
  end

  assign cnt = q;

endmodule

// File: rtl/mem_initiator.sv
// Single-outstanding bus initiator for the single-port memory.
// Request/response valid/ready channels; all outputs come from flops.
module mem_initiator #(
  parameter int ADDR_WIDTH = mem_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = mem_pkg::DEF_DATA_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  wr_en,
  output logic                  op_en,
  output logic                  cs,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic [15:0]           wr_cnt,
  output logic [15:0]           rd_cnt
);

  import mem_pkg::*;

  if ((RD_LATENCY < 1) || (RD_LATENCY > 7)) begin : g_bad_lat
    $error("mem_initiator: RD_LATENCY must be within 1..7");
  end

  mem_init_state_e state;
  mem_init_state_e state_n;
  logic [2:0]      lat_cnt;
  logic            accept;
  logic            last_wait;
  logic            rsp_done;

  assign accept    = (state == IDLE) && req_ready && req_valid;
  assign last_wait = (state == RD_WAIT) && (lat_cnt == 3'd1);
  assign rsp_done  = (state == RESP) && rsp_valid && rsp_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = req_wr ? WR_CMD : RD_CMD;
      WR_CMD:  state_n = IDLE;
      RD_CMD:  state_n = RD_WAIT;
      RD_WAIT: if (last_wait) state_n = RESP;
      RESP:    if (rsp_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bus strobes are registered off the next state so they line up
  // with the state they belong to without any input-to-output path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      addr_in   <= '0;
      data_in   <= '0;
      wr_en     <= 1'b0;
      op_en     <= 1'b0;
      cs        <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      state     <= state_n;
      req_ready <= (state_n == IDLE);
      cs        <= (state_n == WR_CMD) || (state_n == RD_CMD);
      wr_en     <= (state_n == WR_CMD);
      op_en     <= (state_n == RD_CMD) || (state_n == RD_WAIT);
      rsp_valid <= (state_n == RESP);
      if (accept) begin
        addr_in <= req_addr;
        data_in <= req_wdata;
      end
      if (state == RD_CMD) begin
        lat_cnt <= 3'(RD_LATENCY);
      end else if (state == RD_WAIT) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
      if (last_wait) begin
        rsp_data <= data_out;
      end
    end
  end

  mem_sat_cnt u_wr_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (state == WR_CMD),
    .cnt   (wr_cnt)
  );

  mem_sat_cnt u_rd_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (rsp_done),
    .cnt   (rd_cnt)
  );

endmodule
